timer_run_ctrl: RTL and testbench

Sequencing controller for the timer counter datapath. It owns the run/load/stop state machine, the PCLK prescaler that produces a count-enable tick (/2, /4, /8 or /16 selected by TCR clock-select), and the counter itself. It also owns the overflow/underflow status flags and the interrupt request. It sits between the APB register block (TCR/TDR/TSR fields) and the timer interrupt output; no derived clocks are generated.

---
 rtl/timer_run_ctrl_if.sv | 37 +++
 rtl/timer_run_ctrl.sv | 165 ++++++++++++++++
 tb/tb_timer_run_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_run_ctrl_if.sv
// Register-side bundle for the timer run controller.
// master: APB register block (drives TCR/TDR fields, observes status).
// slave : timer_run_ctrl (consumes control fields, drives TCNT/status/irq).
interface timer_run_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    // Control fields from TCR/TDR and flag-clear/enable bits
    logic             tmr_en;
    logic             tmr_load;
    logic             tmr_dn;
    logic [1:0]       tmr_cks;
    logic [CNT_W-1:0] tmr_tdr;
    logic             ovf_clr;
    logic             udf_clr;
    logic             ovf_ie;
    logic             udf_ie;

    // Status back to the register block and interrupt output
    logic [CNT_W-1:0] tmr_cnt;
    logic             tmr_tick;
    logic             ovf_flg;
    logic             udf_flg;
    logic             tmr_irq;
    logic [1:0]       tmr_state;

    modport master (
        output tmr_en, tmr_load, tmr_dn, tmr_cks, tmr_tdr,
        output ovf_clr, udf_clr, ovf_ie, udf_ie,
        input  tmr_cnt, tmr_tick, ovf_flg, udf_flg, tmr_irq, tmr_state
    );

    modport slave (
        input  tmr_en, tmr_load, tmr_dn, tmr_cks, tmr_tdr,
        input  ovf_clr, udf_clr, ovf_ie, udf_ie,
        output tmr_cnt, tmr_tick, ovf_flg, udf_flg, tmr_irq, tmr_state
    );
endinterface

// File: rtl/timer_run_ctrl.sv
// Timer run controller: IDLE/RUN/LOAD sequencing, PCLK prescaler producing a
// one-cycle count-enable tick (/2../16), up/down counter, sticky overflow and
// underflow flags and a registered interrupt request.
// Optional build macro TIMER_AUTORELOAD_EN: on overflow/underflow the counter
// reloads TDR instead of wrapping (flags are still set).
module timer_run_ctrl #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned PSC_W = 4
) (
    input  logic             pclk,
    input  logic             preset,
    timer_run_ctrl_if.slave  tif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_mask;
    logic [1:0]       cks_q;
    logic             cks_chg;
    logic             tick_q;
    logic             tick_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] wrap_up;
    logic [CNT_W-1:0] wrap_dn;
    logic             ovf_q;
    logic             udf_q;
    logic             irq_q;
    logic             ovf_set;
    logic             udf_set;

`ifdef TIMER_AUTORELOAD_EN
    assign wrap_up = tif.tmr_tdr;
    assign wrap_dn = tif.tmr_tdr;
`else
    assign wrap_up = '0;
    assign wrap_dn = '1;
`endif

    // State register
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a load strobe beats the enable in every state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tif.tmr_load) begin
                    state_d = ST_LOAD;
                end else if (tif.tmr_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tif.tmr_load) begin
                    state_d = ST_LOAD;
                end else if (!tif.tmr_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (tif.tmr_load) begin
                    state_d = ST_LOAD;
                end else if (tif.tmr_en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Low (tmr_cks+1) prescaler bits must be all ones to emit a tick
    always_comb begin
        psc_mask = '0;
        for (int unsigned i = 0; i < PSC_W; i++) begin
            psc_mask[i] = (i <= 32'(tif.tmr_cks));
        end
    end

    assign cks_chg = (tif.tmr_cks != cks_q);
    assign tick_d  = (state_q == ST_RUN) && ((psc_q & psc_mask) == psc_mask);

    // Prescaler and tick register; prescaler restarts outside RUN and on a divider change
    always_ff @(posedge pclk) begin
        if (preset) begin
            psc_q  <= '0;
            cks_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cks_q  <= tif.tmr_cks;
            tick_q <= tick_d;
            if ((state_q != ST_RUN) || cks_chg) begin
                psc_q <= '0;
            end else begin
                psc_q <= psc_q + PSC_W'(1);
            end
        end
    end

    // Counter next value and flag set conditions; a load discards a coincident tick
    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (state_q == ST_LOAD) begin
            cnt_d = tif.tmr_tdr;
        end else if (tick_q) begin
            if (!tif.tmr_dn) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_set = 1'b1;
                    cnt_d   = wrap_up;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    udf_set = 1'b1;
                    cnt_d   = wrap_dn;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    // Counter, sticky flags (set beats clear) and interrupt register
    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_set | (ovf_q & ~tif.ovf_clr);
            udf_q <= udf_set | (udf_q & ~tif.udf_clr);
            irq_q <= (ovf_q & tif.ovf_ie) | (udf_q & tif.udf_ie);
        end
    end

    assign tif.tmr_cnt   = cnt_q;
    assign tif.tmr_tick  = tick_q;
    assign tif.ovf_flg   = ovf_q;
    assign tif.udf_flg   = udf_q;
    assign tif.tmr_irq   = irq_q;
    assign tif.tmr_state = state_q;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Bench for timer_run_ctrl: directed scenarios plus randomized runs checked
// cycle by cycle against an arithmetic model of tick timing and counting.
module tb_timer_run_ctrl;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PSC_W = 4;
`ifdef TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic pclk = 1'b0;
    logic preset;

    timer_run_ctrl_if #(.CNT_W(CNT_W)) tif ();

    timer_run_ctrl #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
        .pclk   (pclk),
        .preset (preset),
        .tif    (tif.slave)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_cnt;
    logic [7:0] m_tdr;
    logic       m_ovf;
    logic       m_udf;
    logic       m_irq;

    // Model of one clock edge: irq follows the pre-edge flags, then an applied tick counts
    task automatic model_edge(input logic app, input logic dn, input logic oclr, input logic uclr);
        logic so;
        logic su;
        so = 1'b0;
        su = 1'b0;
        m_irq = (m_ovf & tif.ovf_ie) | (m_udf & tif.udf_ie);
        if (app) begin
            if (!dn) begin
                if (m_cnt == 8'hFF) begin
                    so    = 1'b1;
                    m_cnt = AR ? m_tdr : 8'h00;
                end else begin
                    m_cnt = m_cnt + 8'd1;
                end
            end else begin
                if (m_cnt == 8'h00) begin
                    su    = 1'b1;
                    m_cnt = AR ? m_tdr : 8'hFF;
                end else begin
                    m_cnt = m_cnt - 8'd1;
                end
            end
        end
        m_ovf = so | (m_ovf & ~oclr);
        m_udf = su | (m_udf & ~uclr);
    endtask

    task automatic test_reset();
        preset        = 1'b1;
        tif.tmr_en    = 1'b0;
        tif.tmr_load  = 1'b0;
        tif.tmr_dn    = 1'b0;
        tif.tmr_cks   = 2'd0;
        tif.tmr_tdr   = 8'h00;
        tif.ovf_clr   = 1'b0;
        tif.udf_clr   = 1'b0;
        tif.ovf_ie    = 1'b0;
        tif.udf_ie    = 1'b0;
        repeat (2) @(negedge pclk);
        checks++;
        if ({tif.tmr_cnt, tif.tmr_tick, tif.ovf_flg, tif.udf_flg, tif.tmr_irq, tif.tmr_state} !== 14'h0) begin
            errors++;
            $display("FAIL reset: cnt=%h tick=%b ovf=%b udf=%b irq=%b state=%0d, required all 0",
                     tif.tmr_cnt, tif.tmr_tick, tif.ovf_flg, tif.udf_flg, tif.tmr_irq, tif.tmr_state);
        end
        preset = 1'b0;
        m_cnt = 8'h00; m_tdr = 8'h00; m_ovf = 1'b0; m_udf = 1'b0; m_irq = 1'b0;
        @(negedge pclk);
        model_edge(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Enable for e_cyc cycles starting from IDLE; optional direction flip after cycle flip_at
    task automatic test_run(input int unsigned e_cyc, input int unsigned flip_at);
        int unsigned d;
        int unsigned seen;
        logic        dn;
        logic        app;
        logic        exp_tick;
        logic [1:0]  exp_state;
        d    = 2 << tif.tmr_cks;
        seen = 0;
        dn   = tif.tmr_dn;
        tif.tmr_en = 1'b1;
        for (int unsigned k = 1; k <= e_cyc + 3; k++) begin
            @(negedge pclk);
            app       = (k >= d + 2) && (((k - 2) % d) == 0) && ((k - 2) <= e_cyc);
            exp_tick  = (k >= d + 1) && (((k - 1) % d) == 0) && ((k - 1) <= e_cyc);
            exp_state = (k <= e_cyc) ? 2'd1 : 2'd0;
            model_edge(app, dn, 1'b0, 1'b0);
            if (tif.tmr_tick === 1'b1) seen++;
            checks++;
            if (tif.tmr_cnt !== m_cnt) begin
                errors++;
                $display("FAIL run_cnt k=%0d: got %h required %h", k, tif.tmr_cnt, m_cnt);
            end
            checks++;
            if (tif.tmr_tick !== exp_tick) begin
                errors++;
                $display("FAIL run_tick k=%0d: got %b required %b", k, tif.tmr_tick, exp_tick);
            end
            checks++;
            if (tif.tmr_state !== exp_state) begin
                errors++;
                $display("FAIL run_state k=%0d: got %0d required %0d", k, tif.tmr_state, exp_state);
            end
            checks++;
            if ({tif.ovf_flg, tif.udf_flg, tif.tmr_irq} !== {m_ovf, m_udf, m_irq}) begin
                errors++;
                $display("FAIL run_flags k=%0d: got ovf/udf/irq=%b%b%b required %b%b%b", k,
                         tif.ovf_flg, tif.udf_flg, tif.tmr_irq, m_ovf, m_udf, m_irq);
            end
            if (k == e_cyc) tif.tmr_en = 1'b0;
            if (k == flip_at) begin
                dn = ~dn;
                tif.tmr_dn = dn;
            end
        end
        checks++;
        if (seen != e_cyc / d) begin
            errors++;
            $display("FAIL tick_count cks=%0d n=%0d: got %0d required %0d", tif.tmr_cks, e_cyc, seen, e_cyc / d);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        tif.tmr_tdr  = v;
        tif.tmr_load = 1'b1;
        @(negedge pclk);
        model_edge(1'b0, 1'b0, 1'b0, 1'b0);
        tif.tmr_load = 1'b0;
        checks++;
        if (tif.tmr_state !== 2'd2) begin
            errors++;
            $display("FAIL load_state: got %0d required 2", tif.tmr_state);
        end
        @(negedge pclk);
        model_edge(1'b0, 1'b0, 1'b0, 1'b0);
        m_tdr = v;
        m_cnt = v;
        checks++;
        if ({tif.tmr_cnt, tif.tmr_state} !== {v, 2'd0}) begin
            errors++;
            $display("FAIL load_value: got cnt=%h state=%0d required cnt=%h state=0", tif.tmr_cnt, tif.tmr_state, v);
        end
    endtask

    task automatic do_clear();
        tif.ovf_clr = 1'b1;
        tif.udf_clr = 1'b1;
        @(negedge pclk);
        model_edge(1'b0, 1'b0, 1'b1, 1'b1);
        tif.ovf_clr = 1'b0;
        tif.udf_clr = 1'b0;
        @(negedge pclk);
        model_edge(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({tif.ovf_flg, tif.udf_flg, tif.tmr_irq} !== 3'b000) begin
            errors++;
            $display("FAIL clear: got ovf/udf/irq=%b%b%b required 000", tif.ovf_flg, tif.udf_flg, tif.tmr_irq);
        end
    endtask

    task automatic test_prescale();
        int unsigned len [4] = '{100, 100, 104, 112};
        for (int unsigned c = 0; c < 4; c++) begin
            tif.tmr_cks = 2'(c);
            @(negedge pclk);
            model_edge(1'b0, 1'b0, 1'b0, 1'b0);
            test_run(len[c], 0);
            if (c == 0) begin
                checks++;
                if (tif.tmr_cnt !== 8'h32) begin
                    errors++;
                    $display("FAIL div2_count: got %h required 32", tif.tmr_cnt);
                end
            end
        end
    endtask

    task automatic test_overflow();
        tif.ovf_ie = 1'b1;
        tif.tmr_cks = 2'd0;
        tif.tmr_dn = 1'b0;
        do_clear();
        do_load(8'hFE);
        test_run(6, 0);
        checks++;
        if ({tif.tmr_cnt, tif.ovf_flg, tif.tmr_irq} !== {(AR ? 8'hFF : 8'h01), 2'b11}) begin
            errors++;
            $display("FAIL overflow: got cnt=%h ovf=%b irq=%b", tif.tmr_cnt, tif.ovf_flg, tif.tmr_irq);
        end
        do_clear();
    endtask

    task automatic test_underflow();
        tif.udf_ie = 1'b1;
        tif.tmr_dn = 1'b1;
        do_load(8'h01);
        test_run(4, 0);
        checks++;
        if ({tif.tmr_cnt, tif.udf_flg, tif.tmr_irq} !== {(AR ? 8'h01 : 8'hFF), 2'b11}) begin
            errors++;
            $display("FAIL underflow: got cnt=%h udf=%b irq=%b", tif.tmr_cnt, tif.udf_flg, tif.tmr_irq);
        end
        tif.udf_ie = 1'b0;
        tif.tmr_dn = 1'b0;
    endtask

    task automatic test_set_clr_collision();
        tif.ovf_ie = 1'b1;
        tif.tmr_cks = 2'd0;
        do_clear();
        do_load(8'hFF);
        tif.tmr_en = 1'b1;
        repeat (3) @(negedge pclk);
        checks++;
        if (tif.ovf_flg !== 1'b0) begin
            errors++;
            $display("FAIL collide_pre: got ovf=%b required 0", tif.ovf_flg);
        end
        // Clear lands on the same edge as the FF->wrap tick
        tif.ovf_clr = 1'b1;
        @(negedge pclk);
        tif.ovf_clr = 1'b0;
        tif.tmr_en  = 1'b0;
        checks++;
        if ({tif.tmr_cnt, tif.ovf_flg} !== {(AR ? 8'hFF : 8'h00), 1'b1}) begin
            errors++;
            $display("FAIL collide_set_wins: got cnt=%h ovf=%b required cnt=%h ovf=1",
                     tif.tmr_cnt, tif.ovf_flg, (AR ? 8'hFF : 8'h00));
        end
        repeat (4) @(negedge pclk);
        m_ovf = 1'b1;
        m_udf = 1'b0;
        m_irq = 1'b1;
    endtask

    task automatic test_load_run_and_reset();
        tif.tmr_en = 1'b1;
        repeat (2) @(negedge pclk);
        tif.tmr_tdr  = 8'h80;
        tif.tmr_load = 1'b1;
        @(negedge pclk);
        tif.tmr_load = 1'b0;
        checks++;
        if ({tif.tmr_state, tif.tmr_tick} !== {2'd2, 1'b1}) begin
            errors++;
            $display("FAIL load_in_run: got state=%0d tick=%b required state=2 tick=1", tif.tmr_state, tif.tmr_tick);
        end
        @(negedge pclk);
        checks++;
        if ({tif.tmr_state, tif.tmr_cnt} !== {2'd1, 8'h80}) begin
            errors++;
            $display("FAIL load_then_run: got state=%0d cnt=%h required state=1 cnt=80", tif.tmr_state, tif.tmr_cnt);
        end
        repeat (5) @(negedge pclk);
        checks++;
        if ({tif.ovf_flg, tif.tmr_irq, tif.tmr_state} !== {2'b11, 2'd1}) begin
            errors++;
            $display("FAIL pre_reset: got ovf=%b irq=%b state=%0d required 1 1 1", tif.ovf_flg, tif.tmr_irq, tif.tmr_state);
        end
        preset = 1'b1;
        @(negedge pclk);
        checks++;
        if ({tif.tmr_cnt, tif.tmr_tick, tif.ovf_flg, tif.udf_flg, tif.tmr_irq, tif.tmr_state} !== 14'h0) begin
            errors++;
            $display("FAIL reset_mid_run: cnt=%h tick=%b ovf=%b udf=%b irq=%b state=%0d, required all 0",
                     tif.tmr_cnt, tif.tmr_tick, tif.ovf_flg, tif.udf_flg, tif.tmr_irq, tif.tmr_state);
        end
        tif.tmr_en = 1'b0;
        tif.ovf_ie = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        m_cnt = 8'h00; m_ovf = 1'b0; m_udf = 1'b0; m_irq = 1'b0;
    endtask

    task automatic test_random();
        int unsigned e_cyc;
        for (int unsigned it = 0; it < 20; it++) begin
            tif.tmr_cks = 2'($urandom_range(0, 3));
            tif.tmr_dn  = 1'($urandom_range(0, 1));
            tif.ovf_ie  = 1'($urandom_range(0, 1));
            tif.udf_ie  = 1'($urandom_range(0, 1));
            do_clear();
            do_load(8'($urandom_range(0, 255)));
            e_cyc = $urandom_range(1, 150);
            test_run(e_cyc, $urandom_range(0, e_cyc));
        end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_overflow();
        test_underflow();
        test_set_clr_collision();
        test_load_run_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
